spi_xfer_ctrl: RTL
==================

# spi_xfer_ctrl

Transfer sequencer for the SPI master. It launches a character transfer on `go` and drives `tip` and `lstclk` into the SPI clock generator. It uses the generator's one-cycle edge strobes (`pos_edge` from cpol_0, `neg_edge` from cpol_1) to shift MOSI out and sample MISO in. It counts bits and returns the received word with a one-cycle `done` pulse.

## Interface
- `MAX_LEN`, default 32: maximum character length in bits; `LW = $clog2(MAX_LEN)`.
- `wb_clk`  in  1  system clock, all state on rising edge.
- `wb_reset_n`  in  1  reset; asynchronous and active-low.
- `go`  in  1  start request, sampled only while `tip`=0.
- `char_len`  in  LW  bits per character; 0 encodes MAX_LEN.
- `lsb`  in  1  1 = bit 0 first, 0 = bit len-1 first.
- `tx_neg`  in  1  1 = MOSI advances on falling SCLK, 0 = on rising.
- `rx_neg`  in  1  1 = MISO sampled on falling SCLK, 0 = on rising.
- `tx_data`  in  MAX_LEN  word to transmit.
- `pos_edge`  in  1  strobe from clock generator (cpol_0): SCLK rises next cycle.
- `neg_edge`  in  1  strobe from clock generator (cpol_1): SCLK falls next cycle.
- `miso`  in  1  serial input.
- `tip`  out  1  transfer in progress, to clock generator.
- `lstclk`  out  1  last bit in flight, to clock generator.
- `mosi`  out  1  serial output.
- `rx_data`  out  MAX_LEN  last received word; bits at index ≥ len are 0.
- `done`  out  1  one-cycle pulse at end of transfer.

## Operation
- States are IDLE (`tip`=0) and XFER (`tip`=1).
- **IDLE + go**:
  - Latch `tx_data`, `char_len`, `lsb`, `tx_neg`, `rx_neg`. Config is ignored after latch.
  - Clear `tx_idx`, `rx_idx` and the rx shift register.
  - Enter XFER.
- **XFER, edge selection**: rx_edge = `rx_neg ? neg_edge : pos_edge`; tx_edge = `tx_neg ? neg_edge : pos_edge`.
- **XFER, on rx_edge**:
  - Store `miso` at `lsb ? rx_idx : len-1-rx_idx`.
  - Then `rx_idx`+1.
- **XFER, on tx_edge**:
  - Advance `tx_idx`+1 only if `tx_idx < rx_idx` (after the rx update of the same cycle) and `tx_idx < len-1`.
  - Otherwise hold. This prevents skipping bit 0 when the tx edge precedes the first sample.
- **mosi**: `tx_reg[lsb ? tx_idx : len-1-tx_idx]` in XFER; 0 in IDLE.
- **lstclk**: 1 while in XFER and `rx_idx == len-1`.
- **Completion**: on the rx_edge that makes `rx_idx == len`:
  - Next cycle: `tip`=0, `lstclk`=0, `done`=1, `rx_data` updated. State returns to IDLE.
  - `rx_data` holds its value until the next completion.
- **Ignored inputs**:
  - `go` while `tip`=1 is ignored, with no queuing.
  - Edge strobes in IDLE are ignored.
- **Simultaneous `pos_edge` and `neg_edge`**: both are processed in the same cycle, rx before tx.
- **Reset**: async assertion at any time, including mid-transfer, forces IDLE. `rx_data` is not updated by an aborted transfer except via the reset clear.
- **Reset values**: `tip`=0, `lstclk`=0, `mosi`=0, `done`=0, `rx_data`=0, indices 0.

## Timing
- `go` high at cycle T (IDLE) → `tip`=1 and `mosi`=first bit at T+1.
- Edge strobe at cycle E → index/mosi update visible at E+1, coincident with the SCLK transition.
- Final rx_edge at cycle S → `done`=1, `rx_data` valid, `tip`=0 at S+1. `done` is low at S+2.
- `go` at S+1 is accepted, giving back-to-back transfers with one IDLE cycle.
- `lstclk` rises at E+1 of the rx_edge for bit len-2. For len=1 it rises at T+1.
- Index width is LW+1 bits; no wrap occurs since completion is at `rx_idx == len`.

## Test plan
- **Mode 0, MSB first**:
  - Stimulus: len=8, `lsb`=0, `tx_neg`=1, `rx_neg`=0, `tx_data`=0xA5; MISO drives 0x3C MSB first via clgen model with divider=1.
  - Required: MOSI bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C; exactly 8 rx samples; one `done`.
- **Mode 1, LSB first**:
  - Stimulus: len=4, `lsb`=1, `tx_neg`=0, `rx_neg`=1, `tx_data`=0x6.
  - Required: first MOSI bit held through the first rising strobe (no skip); MOSI sequence 0,1,1,0; received nibble in `rx_data[3:0]`, upper bits 0.
- **Boundary lengths**:
  - Stimulus: `char_len`=0 with MAX_LEN=32, then `char_len`=1.
  - Required: 32-bit transfer with `lstclk` only during bit 31; then 1-bit transfer with `lstclk`=1 from T+1 and `done` after the single sample.
- **go while busy**:
  - Stimulus: pulse `go` with a new `tx_data` mid-transfer.
  - Required: ignored, original data completes; `go` at the `done` cycle starts a second transfer whose `tip` rises at the next cycle.
- **Reset mid-transfer**:
  - Stimulus: assert `wb_reset_n`=0 asynchronously after 3 of 8 bits.
  - Required: `tip`, `lstclk`, `mosi`, `done`, `rx_data` all 0 immediately without a clock edge; after release, no `done` until a new `go`.
- **Edge strobes in IDLE and simultaneous strobes**:
  - Required: no state change in IDLE; with `pos_edge`=`neg_edge`=1 in one XFER cycle, rx sample is taken and tx advances in that same cycle.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
//
// Transfer sequencer for the SPI master. A start request in IDLE latches the
// character and its framing options, then the block walks through the bits
// using the one-cycle edge strobes of the SPI clock generator: MISO is sampled
// on the receive edge, MOSI advances on the transmit edge. When the last bit
// has been sampled the received word is published together with a one-cycle
// done pulse and the block returns to IDLE.
//
// Parameters
//   MAX_LEN   maximum character length in bits (char_len == 0 selects it)
//   LW        width of char_len, derived as $clog2(MAX_LEN)
//
// Ports
//   wb_clk      in   system clock, all state on the rising edge
//   wb_reset_n  in   asynchronous active-low reset
//   go          in   start request, only looked at while idle
//   char_len    in   bits per character, 0 encodes MAX_LEN
//   lsb         in   1: bit 0 first, 0: bit len-1 first
//   tx_neg      in   1: MOSI advances on falling SCLK, 0: on rising
//   rx_neg      in   1: MISO sampled on falling SCLK, 0: on rising
//   tx_data     in   word to transmit
//   pos_edge    in   clock generator strobe, SCLK rises next cycle
//   neg_edge    in   clock generator strobe, SCLK falls next cycle
//   miso        in   serial input
//   tip         out  transfer in progress
//   lstclk      out  last bit in flight
//   mosi        out  serial output
//   rx_data     out  last completed received word, bits >= len are 0
//   done        out  one-cycle pulse when a transfer completes
// -----------------------------------------------------------------------------
module spi_xfer_ctrl #(
  parameter  int MAX_LEN = 32,
  localparam int LW      = $clog2(MAX_LEN)
) (
  input  logic               wb_clk,
  input  logic               wb_reset_n,
  input  logic               go,
  input  logic [LW-1:0]      char_len,
  input  logic               lsb,
  input  logic               tx_neg,
  input  logic               rx_neg,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               pos_edge,
  input  logic               neg_edge,
  input  logic               miso,
  output logic               tip,
  output logic               lstclk,
  output logic               mosi,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               done
);

  // One extra bit so that an index can reach len (== MAX_LEN) without wrapping.
  localparam int IW = LW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e             state_q,   state_d;
  logic [MAX_LEN-1:0] tx_reg_q,  tx_reg_d;
  logic [MAX_LEN-1:0] rx_sr_q,   rx_sr_d;
  logic [MAX_LEN-1:0] rx_data_q, rx_data_d;
  logic [IW-1:0]      len_q,     len_d;
  logic [IW-1:0]      tx_idx_q,  tx_idx_d;
  logic [IW-1:0]      rx_idx_q,  rx_idx_d;
  logic               lsb_q,     lsb_d;
  logic               tx_neg_q,  tx_neg_d;
  logic               rx_neg_q,  rx_neg_d;
  logic               done_q,    done_d;

  logic               rx_edge;
  logic               tx_edge;
  logic [LW-1:0]      tx_pos;
  logic [LW-1:0]      rx_pos;

  // Map a transfer-order index to a bit position in the character.
  function automatic logic [LW-1:0] bit_pos(input logic [IW-1:0] idx,
                                            input logic          lsb_first,
                                            input logic [IW-1:0] len);
    logic [IW-1:0] pos;
    pos = lsb_first ? idx : (len - idx - IW'(1));
    return LW'(pos);
  endfunction

  // The latched polarity options pick which generator strobe drives each side.
  assign rx_edge = rx_neg_q ? neg_edge : pos_edge;
  assign tx_edge = tx_neg_q ? neg_edge : pos_edge;

  assign tx_pos  = bit_pos(tx_idx_q, lsb_q, len_q);
  assign rx_pos  = bit_pos(rx_idx_q, lsb_q, len_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    tx_reg_d  = tx_reg_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    len_d     = len_q;
    tx_idx_d  = tx_idx_q;
    rx_idx_d  = rx_idx_q;
    lsb_d     = lsb_q;
    tx_neg_d  = tx_neg_q;
    rx_neg_d  = rx_neg_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Strobes are ignored here; only a start request matters.
        if (go) begin
          state_d  = ST_XFER;
          tx_reg_d = tx_data;
          len_d    = (char_len == '0) ? IW'(MAX_LEN) : IW'(char_len);
          lsb_d    = lsb;
          tx_neg_d = tx_neg;
          rx_neg_d = rx_neg;
          tx_idx_d = '0;
          rx_idx_d = '0;
          rx_sr_d  = '0;
        end
      end

      ST_XFER: begin
        // Receive side first, so the transmit decision below sees the
        // updated sample count when both strobes arrive together.
        if (rx_edge) begin
          rx_sr_d[rx_pos] = miso;
          rx_idx_d        = rx_idx_q + IW'(1);
        end

        // MOSI may only run ahead of the samples taken so far; this keeps
        // bit 0 on the line when the transmit edge precedes the first sample.
        if (tx_edge && (tx_idx_q < rx_idx_d) && (tx_idx_q < len_q - IW'(1))) begin
          tx_idx_d = tx_idx_q + IW'(1);
        end

        if (rx_edge && (rx_idx_d == len_q)) begin
          state_d   = ST_IDLE;
          rx_data_d = rx_sr_d;
          done_d    = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      // NOTE: the character buffers are ordinary flops rather than a memory,
      // so they are cleared with the rest; rx_data must read 0 after reset.
      state_q   <= ST_IDLE;
      tx_reg_q  <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      len_q     <= '0;
      tx_idx_q  <= '0;
      rx_idx_q  <= '0;
      lsb_q     <= 1'b0;
      tx_neg_q  <= 1'b0;
      rx_neg_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      tx_reg_q  <= tx_reg_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      len_q     <= len_d;
      tx_idx_q  <= tx_idx_d;
      rx_idx_q  <= rx_idx_d;
      lsb_q     <= lsb_d;
      tx_neg_q  <= tx_neg_d;
      rx_neg_q  <= rx_neg_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from state so reset clears them without a clock edge)
  // ---------------------------------------------------------------------------
  assign tip     = (state_q == ST_XFER);
  assign lstclk  = (state_q == ST_XFER) && (rx_idx_q == len_q - IW'(1));
  assign mosi    = (state_q == ST_XFER) && tx_reg_q[tx_pos];
  assign rx_data = rx_data_q;
  assign done    = done_q;

endmodule
